mem_req_ctrl: RTL and testbench

- Core-side memory request controller that sits directly upstream of the data memory.
- Takes single load/store requests from the execute stage and drives the memory's valid/yumi handshake: request, wait for accept, wait for response, acknowledge.
- Returns load data to the pipeline (byte zero- or sign-extended) and flags alignment and timeout errors.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/mem_req_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Core-side memory request controller.
// Accepts one load/store from the execute stage, runs the valid/yumi
// handshake with the data memory, and returns a single-cycle completion
// pulse carrying extended load data or an error flag. The pipeline is
// stalled while a transaction is outstanding.
module mem_req_ctrl #(
  parameter int TIMEOUT_P = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic        req_byte_i,
  input  logic        req_sext_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        stall_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_valid_o,
  output logic        mem_wen_o,
  output logic        mem_byte_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_yumi_o,
  input  logic        mem_yumi_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_P + 1);
  // Counter value in the final WAIT cycle before the abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_P - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             wen_r;
  logic             byte_r;
  logic             sext_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      rdata_r;
  logic             err_r;
  logic             ready_r;
  logic             mem_valid_r;
  logic             resp_valid_r;

  // Transaction FSM: latches the request, sequences the memory handshake and
  // produces the registered status outputs alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      wen_r        <= 1'b0;
      byte_r       <= 1'b0;
      sext_r       <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      rdata_r      <= '0;
      err_r        <= 1'b0;
      ready_r      <= 1'b1;
      mem_valid_r  <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            wen_r   <= req_wen_i;
            byte_r  <= req_byte_i;
            sext_r  <= req_sext_i;
            addr_r  <= req_addr_i;
            wdata_r <= req_wdata_i;
            rdata_r <= '0;
            ready_r <= 1'b0;
            if (!req_byte_i && (req_addr_i[1:0] != 2'b00)) begin
              err_r        <= 1'b1;
              resp_valid_r <= 1'b1;
              state        <= RESP;
            end else begin
              err_r       <= 1'b0;
              mem_valid_r <= 1'b1;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_yumi_i) begin
            wait_cnt    <= '0;
            mem_valid_r <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem_valid_i) begin
            err_r <= 1'b0;
            if (wen_r) begin
              rdata_r <= '0;
            end else if (byte_r) begin
              rdata_r <= {{24{sext_r & mem_rdata_i[7]}}, mem_rdata_i[7:0]};
            end else begin
              rdata_r <= mem_rdata_i;
            end
            resp_valid_r <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == CNT_LAST) begin
              err_r        <= 1'b1;
              rdata_r      <= '0;
              resp_valid_r <= 1'b1;
              state        <= RESP;
            end
          end
        end
        RESP: begin
          rdata_r      <= '0;
          err_r        <= 1'b0;
          resp_valid_r <= 1'b0;
          ready_r      <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          mem_valid_r  <= 1'b0;
          resp_valid_r <= 1'b0;
          ready_r      <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_r;
  assign stall_o      = (ready_r & req_valid_i) | (state == REQ) | (state == WAIT);
  assign resp_valid_o = resp_valid_r;
  assign resp_rdata_o = rdata_r;
  assign resp_err_o   = err_r;
  assign mem_valid_o  = mem_valid_r;
  assign mem_wen_o    = wen_r;
  assign mem_byte_o   = byte_r;
  assign mem_addr_o   = addr_r;
  assign mem_wdata_o  = wdata_r;
  assign mem_yumi_o   = (state == WAIT) & mem_valid_i;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: a byte-array memory responder with adjustable
// accept/response delays plus a reference memory that predicts every result.
module tb_mem_req_ctrl;

  localparam int TIMEOUT = 8;

  logic        clk;
  logic        reset;
  logic        req_valid_i;
  logic        req_wen_i;
  logic        req_byte_i;
  logic        req_sext_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_ready_o;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_valid_o;
  logic        mem_wen_o;
  logic        mem_byte_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_yumi_o;
  logic        mem_yumi_i;
  logic        mem_valid_i;
  logic [31:0] mem_rdata_i;

  int tests_run;
  int tests_failed;

  logic [7:0] ref_mem [0:127];
  logic [7:0] mdl_mem [0:127];

  mem_req_ctrl #(.TIMEOUT_P(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_wen_i    (req_wen_i),
    .req_byte_i   (req_byte_i),
    .req_sext_i   (req_sext_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_ready_o  (req_ready_o),
    .stall_o      (stall_o),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_valid_o  (mem_valid_o),
    .mem_wen_o    (mem_wen_o),
    .mem_byte_o   (mem_byte_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_yumi_o   (mem_yumi_o),
    .mem_yumi_i   (mem_yumi_i),
    .mem_valid_i  (mem_valid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete transaction: predicts the result from the reference memory,
  // plays the memory side with the given delays and checks every cycle.
  task automatic applyStimulus(input logic wen, input logic byte_acc, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int yumi_delay, input int resp_delay,
                               input logic silent);
    logic        misaligned;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_pulses;
    int          a;
    int          stage;
    int          cur;
    int          grant_cnt;
    int          resp_cnt;
    int          pulses;
    logic [31:0] rd;
    logic [31:0] junk;
    logic [6:0]  idx;
    bit          done;

    misaligned = !byte_acc && (addr[1:0] != 2'b00);
    a          = int'(addr[6:0]);
    exp_err    = 1'b0;
    exp_rdata  = 32'h0;
    exp_pulses = 0;
    if (misaligned) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else begin
      if (wen) begin
        if (byte_acc) begin
          ref_mem[a] = wdata[7:0];
        end else begin
          ref_mem[a]   = wdata[7:0];
          ref_mem[a+1] = wdata[15:8];
          ref_mem[a+2] = wdata[23:16];
          ref_mem[a+3] = wdata[31:24];
        end
      end else if (byte_acc) begin
        exp_rdata = {24'h0, ref_mem[a]};
        if (sext && ref_mem[a][7]) exp_rdata[31:8] = 24'hFFFFFF;
      end else begin
        exp_rdata = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      end
      if (wen) exp_rdata = 32'h0;
      if (silent) begin
        exp_err   = 1'b1;
        exp_rdata = 32'h0;
        exp_lat   = 2 + yumi_delay + TIMEOUT;
      end else begin
        exp_lat    = 3 + yumi_delay + resp_delay;
        exp_pulses = 1;
      end
    end

    req_valid_i = 1'b1;
    req_wen_i   = wen;
    req_byte_i  = byte_acc;
    req_sext_i  = sext;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    #1;
    checkOutput("accept_ready", {31'h0, req_ready_o}, 32'h1);
    checkOutput("accept_stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    req_wen_i   = 1'($urandom);
    req_byte_i  = 1'($urandom);
    req_sext_i  = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;

    stage     = 0;
    grant_cnt = 0;
    resp_cnt  = 0;
    pulses    = 0;
    rd        = 32'h0;
    done      = 1'b0;
    for (int k = 1; k <= exp_lat + 20; k++) begin
      if (k > 1) @(negedge clk);
      mem_yumi_i  = 1'b0;
      mem_valid_i = 1'b0;
      mem_rdata_i = $urandom;
      if (resp_valid_o) begin
        checkOutput("resp_latency", k, exp_lat);
        checkOutput("resp_err", {31'h0, resp_err_o}, {31'h0, exp_err});
        checkOutput("resp_rdata", resp_rdata_o, exp_rdata);
        checkOutput("resp_stall", {31'h0, stall_o}, 32'h0);
        checkOutput("resp_mem_valid", {31'h0, mem_valid_o}, 32'h0);
        checkOutput("yumi_pulses", pulses, exp_pulses);
        done = 1'b1;
        break;
      end
      cur = stage;
      checkOutput("busy_stall", {31'h0, stall_o}, 32'h1);
      checkOutput("busy_ready", {31'h0, req_ready_o}, 32'h0);
      checkOutput("mem_valid", {31'h0, mem_valid_o},
                  {31'h0, (cur == 0) && !misaligned});
      if (cur == 0) begin
        mem_valid_i = 1'($urandom);
        if (!misaligned && mem_valid_o) begin
          checkOutput("mem_addr", mem_addr_o, addr);
          checkOutput("mem_wen", {31'h0, mem_wen_o}, {31'h0, wen});
          checkOutput("mem_byte", {31'h0, mem_byte_o}, {31'h0, byte_acc});
          checkOutput("mem_wdata", mem_wdata_o, wdata);
          if (grant_cnt == yumi_delay) begin
            mem_yumi_i = 1'b1;
            idx = mem_addr_o[6:0];
            if (mem_wen_o) begin
              if (mem_byte_o) begin
                mdl_mem[idx] = mem_wdata_o[7:0];
              end else begin
                mdl_mem[{idx[6:2], 2'd0}] = mem_wdata_o[7:0];
                mdl_mem[{idx[6:2], 2'd1}] = mem_wdata_o[15:8];
                mdl_mem[{idx[6:2], 2'd2}] = mem_wdata_o[23:16];
                mdl_mem[{idx[6:2], 2'd3}] = mem_wdata_o[31:24];
              end
              rd = $urandom;
            end else if (mem_byte_o) begin
              junk = $urandom;
              rd   = {junk[31:8], mdl_mem[idx]};
            end else begin
              rd = {mdl_mem[{idx[6:2], 2'd3}], mdl_mem[{idx[6:2], 2'd2}],
                    mdl_mem[{idx[6:2], 2'd1}], mdl_mem[{idx[6:2], 2'd0}]};
            end
            stage    = 1;
            resp_cnt = resp_delay;
          end else begin
            grant_cnt++;
          end
        end
      end else if (cur == 1 && !silent) begin
        if (resp_cnt == 0) begin
          mem_valid_i = 1'b1;
          mem_rdata_i = rd;
        end else begin
          resp_cnt--;
        end
      end
      #1;
      checkOutput("mem_yumi", {31'h0, mem_yumi_o}, {31'h0, (cur == 1) && mem_valid_i});
      if (mem_yumi_o) pulses++;
      if (cur == 1 && mem_valid_i && mem_yumi_o) stage = 2;
    end
    if (!done) begin
      checkOutput("resp_arrived", 32'h0, 32'h1);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
    end
    mem_yumi_i  = 1'b0;
    mem_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("after_resp_ready", {31'h0, req_ready_o}, 32'h1);
    checkOutput("after_resp_valid", {31'h0, resp_valid_o}, 32'h0);
  endtask

  // Starts a load, lets the memory accept it, then resets in WAIT.
  task automatic resetInWait(input logic [31:0] addr);
    req_valid_i = 1'b1;
    req_wen_i   = 1'b0;
    req_byte_i  = 1'b0;
    req_sext_i  = 1'b0;
    req_addr_i  = addr;
    req_wdata_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    checkOutput("rst_req_valid", {31'h0, mem_valid_o}, 32'h1);
    mem_yumi_i = 1'b1;
    @(negedge clk);
    mem_yumi_i = 1'b0;
    checkOutput("rst_wait_valid", {31'h0, mem_valid_o}, 32'h0);
    checkOutput("rst_wait_stall", {31'h0, stall_o}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_ready", {31'h0, req_ready_o}, 32'h1);
    checkOutput("rst_stall", {31'h0, stall_o}, 32'h0);
    checkOutput("rst_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    checkOutput("rst_rdata", resp_rdata_o, 32'h0);
    checkOutput("rst_err", {31'h0, resp_err_o}, 32'h0);
    checkOutput("rst_mem_valid", {31'h0, mem_valid_o}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 32'h0);
    checkOutput("rst_mem_yumi", {31'h0, mem_yumi_o}, 32'h0);
    @(negedge clk);
    checkOutput("rst_no_resp", {31'h0, resp_valid_o}, 32'h0);
    checkOutput("rst_idle_ready", {31'h0, req_ready_o}, 32'h1);
  endtask

  // Main sequence: reset checks, directed scenarios, then random traffic.
  initial begin
    logic [31:0] v;
    logic        wen;
    logic        byte_acc;
    logic [31:0] addr;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    req_valid_i  = 1'b0;
    req_wen_i    = 1'b0;
    req_byte_i   = 1'b0;
    req_sext_i   = 1'b0;
    req_addr_i   = 32'h0;
    req_wdata_i  = 32'h0;
    mem_yumi_i   = 1'b0;
    mem_valid_i  = 1'b0;
    mem_rdata_i  = 32'h0;
    for (int i = 0; i < 128; i++) begin
      v          = $urandom;
      ref_mem[i] = v[7:0];
      mdl_mem[i] = v[7:0];
    end

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'h0, req_ready_o}, 32'h1);
    checkOutput("reset_stall", {31'h0, stall_o}, 32'h0);
    checkOutput("reset_resp_valid", {31'h0, resp_valid_o}, 32'h0);
    checkOutput("reset_rdata", resp_rdata_o, 32'h0);
    checkOutput("reset_err", {31'h0, resp_err_o}, 32'h0);
    checkOutput("reset_mem_valid", {31'h0, mem_valid_o}, 32'h0);
    checkOutput("reset_mem_wen", {31'h0, mem_wen_o}, 32'h0);
    checkOutput("reset_mem_byte", {31'h0, mem_byte_o}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata_o, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h21, 32'hABCDEF80, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h21, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h21, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 3, 5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 0, TIMEOUT - 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 1, 1, 1'b0);
    resetInWait(32'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 0, 0, 1'b0);

    for (int n = 0; n < 160; n++) begin
      wen      = 1'($urandom);
      byte_acc = 1'($urandom);
      addr     = $urandom_range(0, 127);
      if (!byte_acc && ($urandom_range(0, 3) != 0)) addr[1:0] = 2'b00;
      applyStimulus(wen, byte_acc, 1'($urandom), addr, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1),
                    $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          checkOutput("gap_ready", {31'h0, req_ready_o}, 32'h1);
          checkOutput("gap_stall", {31'h0, stall_o}, 32'h0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
